// File: rtl/uart_pkg.sv
// Shared constants and serializer state encoding for the buffered UART transmitter.
// UART_TX_PARITY_EN adds an even-parity state between DATA and STOP.
package uart_pkg;

  // 27 MHz / 115200 baud
  localparam int CLKS_PER_BIT_DEF = 234;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;
`endif

  function automatic logic even_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Producer-side byte handshake (valid/ready) for uart_tx_buffered.
// Ports: none; signals valid, data[7:0], ready; modports master / slave.
interface uart_tx_buffered_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pointers wrap modulo DEPTH.
// Ports: clk, rst_n, push/wdata, pop/rdata (head), full, empty, count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)      count <= count + 1'b1;
      else if (rd_en && !wr_en) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter, 8N1 (8E1 when UART_TX_PARITY_EN is defined).
// Ports: i_Clock, i_Rst_n, i_Tx_Valid/i_Tx_Byte/o_Tx_Ready (byte handshake),
//        o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Fifo_Count.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_Tx_Valid,
  input  logic [7:0]                    i_Tx_Byte,
  output logic                          o_Tx_Ready,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    idx_nx;
  logic [7:0]    tx_data;
`ifdef UART_TX_PARITY_EN
  logic          tx_par;
`endif

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic          cnt_last;

  assign o_Tx_Ready = ~full;
  assign push       = i_Tx_Valid & o_Tx_Ready;
  assign cnt_last   = (clk_cnt == CNT_LAST);
  assign idx_nx     = bit_idx + 3'd1;

  // Pop in IDLE, or on the last STOP cycle so the next frame starts gap-free.
  assign pop = ~empty &
               ((state == ST_IDLE) | ((state == ST_STOP) & cnt_last));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_Clock),
    .rst_n (i_Rst_n),
    .push  (push),
    .wdata (i_Tx_Byte),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (o_Fifo_Count)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= ST_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      tx_data     <= '0;
`ifdef UART_TX_PARITY_EN
      tx_par      <= 1'b0;
`endif
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          clk_cnt <= '0;
          if (pop) begin
            state       <= ST_START;
            tx_data     <= head;
`ifdef UART_TX_PARITY_EN
            tx_par      <= even_par(head);
`endif
            bit_idx     <= '0;
            o_Tx_Serial <= 1'b0;
            o_Tx_Active <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt_last) begin
            clk_cnt     <= '0;
            state       <= ST_DATA;
            o_Tx_Serial <= tx_data[0];
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_last) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx     <= '0;
`ifdef UART_TX_PARITY_EN
              state       <= ST_PARITY;
              o_Tx_Serial <= tx_par;
`else
              state       <= ST_STOP;
              o_Tx_Serial <= 1'b1;
`endif
            end else begin
              bit_idx     <= idx_nx;
              o_Tx_Serial <= tx_data[idx_nx];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (cnt_last) begin
            clk_cnt     <= '0;
            state       <= ST_STOP;
            o_Tx_Serial <= 1'b1;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (cnt_last) begin
            clk_cnt   <= '0;
            o_Tx_Done <= 1'b1;
            if (pop) begin
              state       <= ST_START;
              tx_data     <= head;
`ifdef UART_TX_PARITY_EN
              tx_par      <= even_par(head);
`endif
              bit_idx     <= '0;
              o_Tx_Serial <= 1'b0;
            end else begin
              state       <= ST_IDLE;
              o_Tx_Active <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          clk_cnt     <= '0;
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Define UART_TX_PARITY_EN for both bench and RTL to exercise the parity frame.
module tb_uart_tx_buffered;

  localparam int C = 4;
  localparam int D = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic       serial;
  logic       active;
  logic       done;
  logic [2:0] count;

  int checks;
  int failures;
  int wait_n;

  uart_tx_buffered_if tx_if ();

  uart_tx_buffered #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .i_Clock      (clk),
    .i_Rst_n      (rst_n),
    .i_Tx_Valid   (tx_if.valid),
    .i_Tx_Byte    (tx_if.data),
    .o_Tx_Ready   (tx_if.ready),
    .o_Tx_Serial  (serial),
    .o_Tx_Active  (active),
    .o_Tx_Done    (done),
    .o_Fifo_Count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Follows one frame cycle by cycle; ends on the negedge where done is due.
  task automatic rx_frame(input string tag, input logic [7:0] b,
                          input bit contig);
    logic [10:0] frm;
    bit ok;
    int n;
    if (FB == 11) frm = {1'b1, ^b, b, 1'b0};
    else          frm = {2'b11, b, 1'b0};
    if (contig) begin
      chk({tag, "_nogap"}, serial, 0);
    end else begin
      ok = 0;
      n  = 0;
      while (!ok && n < 200) begin
        @(negedge clk);
        n++;
        if (serial === 1'b0) ok = 1;
      end
      wait_n = n;
      chk({tag, "_start_seen"}, ok, 1);
      if (!ok) return;
    end
    for (int j = 0; j < FB * C; j++) begin
      if (j > 0) begin
        @(negedge clk);
        chk({tag, "_done_low"}, done, 0);
      end
      chk({tag, "_line"}, serial, frm[j / C]);
      chk({tag, "_active"}, active, 1);
    end
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
  endtask

  task automatic idle_watch(input string tag, input int n);
    bit ok;
    ok = 1;
    repeat (n) begin
      @(negedge clk);
      if (serial !== 1'b1 || active !== 1'b0) ok = 0;
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    wait_n      = 0;
    rst_n       = 1'b0;
    tx_if.valid = 1'b0;
    tx_if.data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_serial", serial, 1);
    chk("rst_active", active, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_ready", tx_if.ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // single byte
    fork
      begin
        tx_if.valid = 1'b1;
        tx_if.data  = 8'h55;
        @(negedge clk);
        tx_if.valid = 1'b0;
      end
      rx_frame("t1", 8'h55, 0);
    join
    chk("t1_latency", wait_n, 2);
    chk("t1_end_active", active, 0);
    chk("t1_end_serial", serial, 1);
    @(negedge clk);
    chk("t1_done_pulse", done, 0);
    chk("t1_count", count, 0);

    // back-to-back
    fork
      begin
        tx_if.valid = 1'b1;
        tx_if.data  = 8'hA5;
        @(negedge clk);
        tx_if.data  = 8'h3C;
        @(negedge clk);
        tx_if.data  = 8'hFF;
        @(negedge clk);
        tx_if.valid = 1'b0;
      end
      begin
        rx_frame("t2a", 8'hA5, 0);
        rx_frame("t2b", 8'h3C, 1);
        rx_frame("t2c", 8'hFF, 1);
      end
    join
    chk("t2_end_active", active, 0);
    idle_watch("t2_idle", 10);

    // full FIFO: 0x15..0x17 offered while full must be dropped
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          if (i == 4) begin
            chk("t3_ready3", tx_if.ready, 1);
            chk("t3_count3", count, 3);
          end
          if (i == 5) begin
            chk("t3_ready4", tx_if.ready, 0);
            chk("t3_count4", count, 4);
          end
          tx_if.valid = 1'b1;
          tx_if.data  = 8'(16 + i);
          @(negedge clk);
        end
        tx_if.valid = 1'b0;
      end
      begin
        rx_frame("t3_10", 8'h10, 0);
        rx_frame("t3_11", 8'h11, 1);
        rx_frame("t3_12", 8'h12, 1);
        rx_frame("t3_13", 8'h13, 1);
        rx_frame("t3_14", 8'h14, 1);
      end
    join
    chk("t3_end_active", active, 0);
    idle_watch("t3_no_extra", 60);
    chk("t3_count0", count, 0);

    // push on the same edge as the STOP-end pop
    fork
      begin
        tx_if.valid = 1'b1;
        tx_if.data  = 8'hC1;
        @(negedge clk);
        tx_if.data  = 8'hC2;
        @(negedge clk);
        tx_if.data  = 8'hC3;
        @(negedge clk);
        tx_if.valid = 1'b0;
        repeat (FB * C - 2) @(negedge clk);
        chk("t4_pre_count", count, 2);
        tx_if.valid = 1'b1;
        tx_if.data  = 8'hC4;
        @(negedge clk);
        tx_if.valid = 1'b0;
        chk("t4_post_count", count, 2);
        chk("t4_post_done", done, 1);
      end
      begin
        rx_frame("t4_c1", 8'hC1, 0);
        rx_frame("t4_c2", 8'hC2, 1);
        rx_frame("t4_c3", 8'hC3, 1);
        rx_frame("t4_c4", 8'hC4, 1);
      end
    join
    chk("t4_end_active", active, 0);

    // reset during data bit 3 of 0x00 with three bytes queued
    tx_if.valid = 1'b1;
    tx_if.data  = 8'h00;
    @(negedge clk);
    tx_if.data  = 8'h11;
    @(negedge clk);
    tx_if.data  = 8'h22;
    @(negedge clk);
    tx_if.data  = 8'h33;
    @(negedge clk);
    tx_if.valid = 1'b0;
    chk("t5_count3", count, 3);
    repeat (15) @(negedge clk);
    chk("t5_pre_serial", serial, 0);
    chk("t5_pre_active", active, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_serial", serial, 1);
    chk("t5_rst_count", count, 0);
    chk("t5_rst_active", active, 0);
    chk("t5_rst_ready", tx_if.ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_watch("t5_quiet", 80);
    chk("t5_count0", count, 0);
    fork
      begin
        tx_if.valid = 1'b1;
        tx_if.data  = 8'h5A;
        @(negedge clk);
        tx_if.valid = 1'b0;
      end
      rx_frame("t5_new", 8'h5A, 0);
    join
    chk("t5_new_latency", wait_n, 2);

`ifdef UART_TX_PARITY_EN
    idle_watch("t6_idle", 4);
    fork
      begin
        tx_if.valid = 1'b1;
        tx_if.data  = 8'h07;
        @(negedge clk);
        tx_if.data  = 8'h03;
        @(negedge clk);
        tx_if.valid = 1'b0;
      end
      begin
        rx_frame("t6_07", 8'h07, 0);
        rx_frame("t6_03", 8'h03, 1);
      end
    join
    chk("t6_end_active", active, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
